// File: rtl/memory_arbiter.sv
// Arbitrates the cache's instruction and data requests onto the single-ported system RAM.
// Data wins by default; after a data access, a contending fetch gets the next turn. A timeout/error guard bounds every access.
module memory_arbiter #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic        i_CLK,
  input  logic        i_nRST,
  input  logic        i_iREN,
  input  logic [31:0] i_iaddr,
  output logic        o_iwait,
  output logic [31:0] o_iload,
  input  logic        i_dREN,
  input  logic        i_dWEN,
  input  logic [31:0] i_daddr,
  input  logic [31:0] i_dstore,
  output logic        o_dwait,
  output logic [31:0] o_dload,
  output logic        o_ramREN,
  output logic        o_ramWEN,
  output logic [31:0] o_ramaddr,
  output logic [31:0] o_ramstore,
  input  logic [31:0] i_ramload,
  input  logic [1:0]  i_ramstate,
  output logic        o_memerr
);

  localparam int              CW        = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT - 1);
  localparam logic [1:0]      RS_ACCESS = 2'b10;
  localparam logic [1:0]      RS_ERROR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_IACC = 2'b01,
    S_DACC = 2'b10
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_last_d;
  logic          r_memerr;
  logic          w_acc;
  logic          w_req;
  logic          w_ok;
  logic          w_err;
  logic          w_abort;
  logic          w_done;
  logic [31:0]   w_result;

  // Classify the current access cycle: normal completion, abort, or error/timeout completion.
  always_comb begin
    w_acc   = i_nRST && ((r_state == S_IACC) || (r_state == S_DACC));
    w_req   = (r_state == S_IACC) ? i_iREN : (i_dREN | i_dWEN);
    w_ok    = 1'b0;
    w_err   = 1'b0;
    w_abort = 1'b0;
    if (w_acc) begin
      if (i_ramstate == RS_ACCESS) begin
        w_ok = 1'b1;
      end else if (!w_req) begin
        w_abort = 1'b1;
      end else if ((i_ramstate == RS_ERROR) || (r_cnt == CNT_LAST)) begin
        w_err = 1'b1;
      end else begin
        w_ok = 1'b0;
      end
    end else begin
      w_ok = 1'b0;
    end
    w_done   = w_ok | w_err;
    w_result = w_ok ? i_ramload : ERRWORD;
  end

  // Next-state selection and RAM/requester output drive.
  always_comb begin
    w_next     = r_state;
    o_iwait    = 1'b1;
    o_dwait    = 1'b1;
    o_iload    = 32'h0000_0000;
    o_dload    = 32'h0000_0000;
    o_ramREN   = 1'b0;
    o_ramWEN   = 1'b0;
    o_ramaddr  = 32'h0000_0000;
    o_ramstore = 32'h0000_0000;
    case (r_state)
      S_IDLE: begin
        if ((i_dREN | i_dWEN) && i_iREN && r_last_d) begin
          w_next = S_IACC;
        end else if (i_dREN | i_dWEN) begin
          w_next = S_DACC;
        end else if (i_iREN) begin
          w_next = S_IACC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_IACC: begin
        if (i_nRST) begin
          o_ramREN  = 1'b1;
          o_ramaddr = i_iaddr;
        end else begin
          o_ramREN = 1'b0;
        end
        if (w_done) begin
          o_iwait = 1'b0;
          o_iload = w_result;
        end else begin
          o_iwait = 1'b1;
        end
      end
      S_DACC: begin
        if (i_nRST) begin
          o_ramaddr  = i_daddr;
          o_ramstore = i_dstore;
          o_ramWEN   = i_dWEN;
          o_ramREN   = ~i_dWEN;
        end else begin
          o_ramREN = 1'b0;
        end
        if (w_done) begin
          o_dwait = 1'b0;
          o_dload = w_result;
        end else begin
          o_dwait = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (w_done || w_abort) begin
      w_next = S_IDLE;
    end else begin
      w_next = w_next;
    end
  end

  // State, access counter, fairness flag and sticky error flag.
  always_ff @(posedge i_CLK) begin
    if (!i_nRST) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_last_d <= 1'b0;
      r_memerr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        r_cnt <= {CW{1'b0}};
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_done) begin
        r_last_d <= (r_state == S_DACC);
      end
      if (w_err) begin
        r_memerr <= 1'b1;
      end
    end
  end

  assign o_memerr = r_memerr;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic,
// each cycle compared against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] ERRWORD = 32'hBAD1BAD1;
  localparam logic [1:0]  FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;
  localparam int          G_NONE = 0, G_I = 1, G_D = 2;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        iren = 1'b0, dren = 1'b0, dwen = 1'b0;
  logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0, ramload = 32'h0;
  logic [1:0]  ramstate = FREE;
  logic        iwait, dwait, ramren, ramwen, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // reference model: who holds the RAM, how many access cycles have elapsed, fairness, error flag
  int   m_grant = G_NONE;
  int   m_cycles = 0;
  logic m_last_d = 1'b0;
  logic m_err = 1'b0;

  memory_arbiter #(.TIMEOUT(TIMEOUT), .ERRWORD(ERRWORD)) dut (
    .i_CLK(clk), .i_nRST(nrst),
    .i_iREN(iren), .i_iaddr(iaddr), .o_iwait(iwait), .o_iload(iload),
    .i_dREN(dren), .i_dWEN(dwen), .i_daddr(daddr), .i_dstore(dstore),
    .o_dwait(dwait), .o_dload(dload),
    .o_ramREN(ramren), .o_ramWEN(ramwen), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
    .i_ramload(ramload), .i_ramstate(ramstate), .o_memerr(memerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare all outputs to the model, advance the model.
  task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [31:0] da,
                      input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] rl);
    logic        e_iwait, e_dwait, e_ren, e_wen;
    logic [31:0] e_iload, e_dload, e_addr, e_store, res;
    logic        req, ok, err, abort;
    @(negedge clk);
    nrst = rst; iren = ir; iaddr = ia; dren = dr; dwen = dw;
    daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    #1;
    cyc++;
    e_iwait = 1'b1; e_dwait = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
    e_iload = 32'h0; e_dload = 32'h0; e_addr = 32'h0; e_store = 32'h0;
    ok = 1'b0; err = 1'b0; abort = 1'b0;
    if (rst && m_grant != G_NONE) begin
      req   = (m_grant == G_I) ? ir : (dr | dw);
      ok    = (rs == ACCESS);
      abort = !ok && !req;
      err   = !ok && !abort && ((rs == ERROR) || (m_cycles + 1 == TIMEOUT));
      res   = ok ? rl : ERRWORD;
      if (m_grant == G_I) begin
        e_ren = 1'b1; e_addr = ia;
        if (ok || err) begin e_iwait = 1'b0; e_iload = res; end
      end else begin
        e_ren = !dw; e_wen = dw; e_addr = da; e_store = ds;
        if (ok || err) begin e_dwait = 1'b0; e_dload = res; end
      end
    end
    check("iwait", {31'b0, iwait}, {31'b0, e_iwait});
    check("dwait", {31'b0, dwait}, {31'b0, e_dwait});
    check("iload", iload, e_iload);
    check("dload", dload, e_dload);
    check("ramREN", {31'b0, ramren}, {31'b0, e_ren});
    check("ramWEN", {31'b0, ramwen}, {31'b0, e_wen});
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("memerr", {31'b0, memerr}, {31'b0, m_err});
    if (!rst) begin
      m_grant = G_NONE; m_cycles = 0; m_last_d = 1'b0; m_err = 1'b0;
    end else if (m_grant == G_NONE) begin
      m_cycles = 0;
      if ((dr | dw) && !(ir && m_last_d)) m_grant = G_D;
      else if (ir) m_grant = G_I;
    end else if (ok || err) begin
      m_last_d = (m_grant == G_D);
      if (err) m_err = 1'b1;
      m_grant = G_NONE;
    end else if (abort) begin
      m_grant = G_NONE;
    end else begin
      m_cycles++;
    end
  endtask

  initial begin
    logic        r_ir, r_dr, r_dw;
    logic [1:0]  r_rs;
    int          pick;
    nrst = 1'b0; iren = 1'b1; dren = 1'b1;
    repeat (2) @(posedge clk);

    // reset held with both requests active
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, ACCESS, 32'h55);
    check("rst_iwait", {31'b0, iwait}, 32'd1);
    check("rst_dwait", {31'b0, dwait}, 32'd1);
    check("rst_ramaddr", ramaddr, 32'h0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, BUSY, 32'h0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0, ACCESS, 32'h1234);
    check("first_grant_d", ramaddr, 32'h20);
    check("first_dwait", {31'b0, dwait}, 32'd0);

    // write wins over read
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, FREE, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, BUSY, 32'h0);
    check("wr_ramWEN", {31'b0, ramwen}, 32'd1);
    check("wr_ramREN", {31'b0, ramren}, 32'd0);
    check("wr_ramaddr", ramaddr, 32'h100);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, ACCESS, 32'h0);
    check("wr_dwait", {31'b0, dwait}, 32'd0);

    // instruction fetch with two BUSY cycles
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
      check("if_wait_busy", {31'b0, iwait}, 32'd1);
    end
    step(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h8C010004);
    check("if_iwait", {31'b0, iwait}, 32'd0);
    check("if_iload", iload, 32'h8C010004);
    step(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h0);
    check("if_idle", {31'b0, ramren}, 32'd0);

    // contention with RAM always ready: D, I, D, I with an IDLE between
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, ACCESS, 32'hA0 + k);
      if (k % 2 == 0) check("alt_idle", {31'b0, ramren}, 32'd0);
      else check("alt_addr", ramaddr, (k % 4 == 1) ? 32'h2000 : 32'h1000);
    end

    // abort: data request dropped in its second access cycle
    step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
    step(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
    check("abort_dwait", {31'b0, dwait}, 32'd1);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h300, 32'h0, BUSY, 32'h0);
    check("abort_idle", {31'b0, ramren}, 32'd0);
    step(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h300, 32'h0, ACCESS, 32'h77);
    check("abort_then_i", ramaddr, 32'h44);
    check("abort_memerr", {31'b0, memerr}, 32'd0);

    // timeout with RAM stuck BUSY
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, BUSY, 32'h0);
    for (int k = 1; k <= TIMEOUT; k++) begin
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, BUSY, 32'h0);
      check("to_dwait", {31'b0, dwait}, (k == TIMEOUT) ? 32'd0 : 32'd1);
    end
    check("to_dload", dload, 32'hBAD1BAD1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
    check("to_memerr", {31'b0, memerr}, 32'd1);

    // immediate ERROR completion
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    step(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h99);
    check("err_iwait", {31'b0, iwait}, 32'd0);
    check("err_iload", iload, 32'hBAD1BAD1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    check("err_memerr_sticky", {31'b0, memerr}, 32'd1);

    // randomized traffic, with occasional reset and long BUSY windows
    r_ir = 1'b0; r_dr = 1'b0; r_dw = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) r_ir = ~r_ir;
      if ($urandom_range(0, 5) == 0) r_dr = ~r_dr;
      if ($urandom_range(0, 7) == 0) r_dw = ~r_dw;
      pick = $urandom_range(0, 15);
      if (k % 150 < 25) r_rs = BUSY;
      else if (pick < 6) r_rs = BUSY;
      else if (pick < 8) r_rs = FREE;
      else if (pick < 15) r_rs = ACCESS;
      else r_rs = ERROR;
      step(($urandom_range(0, 199) != 0), r_ir, $urandom(), r_dr, r_dw,
           $urandom(), $urandom(), r_rs, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter between the cache block's memory-side port and the single-ported system RAM. The caches raise independent instruction-read and data-read/write requests. This block grants one of them at a time and drives the RAM port from the granted requester. It returns wait/load to the winner and holds the loser in wait. Data requests have priority, with one-shot anti-starvation for instruction fetch, plus a timeout/error guard on RAM accesses.

## Interface
Parameters:
- TIMEOUT, 16 — max cycles in an access state without RAM ACCESS before forced completion.
- ERRWORD, 32'hBAD1BAD1 — load value returned on error/timeout completion.

Ports:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  reset; synchronous, active-low.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction address.
- iwait  out  1  low only in the cycle the instruction access completes.
- iload  out  32  instruction word; valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; wins over dREN if both high.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  low only in the cycle the data access completes.
- dload  out  32  read data; valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- memerr  out  1  sticky; set on timeout or ERROR.

## Operation
- FSM states: IDLE, IACC, DACC.
- IDLE: no RAM enables; both waits high. At the clock edge, choose the next state:
  - dreq = dREN|dWEN.
  - If dreq and iREN and last_d=1, go to IACC.
  - Else if dreq, go to DACC.
  - Else if iREN, go to IACC.
  - Else stay in IDLE.
- IACC: ramREN=1, ramaddr=iaddr (live), ramWEN=0.
- DACC: ramaddr=daddr, ramstore=dstore.
  - dWEN=1 → ramWEN=1, ramREN=0.
  - Otherwise ramREN=1.
- Completion, same cycle as ramstate==ACCESS in xACC:
  - The granted wait goes low.
  - The granted load equals ramload; on a write, dload equals ramload (don't-care).
  - The next state is IDLE.
  - last_d is set to 1 if the access was data, else 0.
- Error completion: ramstate==ERROR, or the counter reaching TIMEOUT-1 without ACCESS.
  - The granted wait goes low.
  - The granted load is ERRWORD.
  - memerr is set.
  - The next state is IDLE; last_d is updated as for normal completion.
- Abort: the granted request drops while in xACC with no ACCESS that cycle.
  - The next state is IDLE.
  - No wait deassertion; last_d is unchanged; no error.
- Counter: cleared in IDLE, incremented each xACC cycle, width clog2(TIMEOUT)+1.
- The non-granted wait is always high. Each load output is 0 whenever its wait is high.
- memerr clears only on reset.

## Timing
- Reset (nRST low at the edge) → IDLE, counter 0, last_d 0, memerr 0. Reset overrides an in-flight access; no completion is signalled.
- Outputs during and after reset:
  - iwait=1, dwait=1.
  - iload=0, dload=0.
  - ramREN=0, ramWEN=0.
  - ramaddr=0, ramstore=0.
- Minimum access: request seen in IDLE at cycle n → xACC at n+1 → if ACCESS at n+1, wait low at n+1 → IDLE at n+2.
  - Back-to-back accesses take 2 cycles each; the IDLE bubble drops RAM enables between accesses.
- Completion outputs are combinational from ramstate/ramload in the xACC cycle. All state changes are registered.
- Requests arriving while in xACC are ignored until the return to IDLE.
- Timeout: without ACCESS, completion occurs on the TIMEOUT-th xACC cycle.

## Test plan
- Reset with iREN=1 and dREN=1 held → all outputs at reset values; after release the first grant is DACC.
- iREN only, iaddr=0x40, RAM gives ACCESS after 2 BUSY cycles with ramload=0x8C010004 → iwait low exactly in the 3rd IACC cycle, iload=0x8C010004, then IDLE.
- dWEN and dREN both high, daddr=0x100, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramaddr=0x100, ramstore=0xDEADBEEF; dwait low on ACCESS.
- iREN and dREN held continuously, RAM always ACCESS → grants alternate DACC, IACC, DACC, IACC with an IDLE between each.
- RAM stuck BUSY with TIMEOUT=16 → wait low on the 16th cycle, load=0xBAD1BAD1, memerr=1 and stays 1. ramstate=ERROR gives the same completion immediately.
- dREN dropped during the 2nd DACC cycle → IDLE next cycle, dwait never low, memerr=0; a pending iREN is granted next.
